// File: rtl/motion_cmd_arbiter_if.sv
// Operator-input and motion-command bundle shared by the arbiter and its neighbours.
// The master side drives keys, IR pulses and the obstacle flag; the slave side (arbiter) returns commands.
interface motion_cmd_arbiter_if;
    logic       key1;
    logic       key2;
    logic       key3;
    logic       key4;
    logic       ir_forward;
    logic       ir_back;
    logic       ir_left;
    logic       ir_right;
    logic       ir_stop;
    logic       hr_flag_short;
    logic       cmd_forward;
    logic       cmd_back;
    logic       cmd_left;
    logic       cmd_right;
    logic       cmd_stop;
    logic [2:0] cmd_state;
    logic       auto_stop;

    modport master (
        output key1, key2, key3, key4,
        output ir_forward, ir_back, ir_left, ir_right, ir_stop,
        output hr_flag_short,
        input  cmd_forward, cmd_back, cmd_left, cmd_right, cmd_stop,
        input  cmd_state, auto_stop
    );

    modport slave (
        input  key1, key2, key3, key4,
        input  ir_forward, ir_back, ir_left, ir_right, ir_stop,
        input  hr_flag_short,
        output cmd_forward, cmd_back, cmd_left, cmd_right, cmd_stop,
        output cmd_state, auto_stop
    );
endinterface

// File: rtl/motion_cmd_arbiter.sv
// Motion-command front end: debounced keys + IR pulses -> prioritised single-cycle commands with
// obstacle auto-stop. Define MOTION_CMD_WDOG_EN to add the idle-timeout auto-stop.
module motion_cmd_arbiter #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int WDOG_CYCLES = 250000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    motion_cmd_arbiter_if.slave  bus
);

    localparam int            DW       = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_STOP  = 3'd0,
        ST_FWD   = 3'd1,
        ST_BACK  = 3'd2,
        ST_LEFT  = 3'd3,
        ST_RIGHT = 3'd4
    } state_t;

    // Key index order: 0 forward, 1 back, 2 left, 3 right.
    logic [3:0] key_raw;
    logic [3:0] press;

    assign key_raw = {bus.key4, bus.key3, bus.key2, bus.key1};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_deb
            logic          sync1_reg;
            logic          sync2_reg;
            logic          level_reg;
            logic          press_reg;
            logic [DW-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg <= 1'b1;
                    sync2_reg <= 1'b1;
                    level_reg <= 1'b1;
                    press_reg <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= key_raw[gi];
                    sync2_reg <= sync1_reg;
                    press_reg <= 1'b0;
                    if (sync2_reg == level_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        level_reg <= sync2_reg;
                        cnt_reg   <= '0;
                        // only the falling (press) edge of the debounced level is a request
                        press_reg <= ~sync2_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign press[gi] = press_reg;
        end
    endgenerate

    logic req_fwd;
    logic req_back;
    logic req_left;
    logic req_right;
    logic req_stop;

    assign req_fwd   = press[0] | bus.ir_forward;
    assign req_back  = press[1] | bus.ir_back;
    assign req_left  = press[2] | bus.ir_left;
    assign req_right = press[3] | bus.ir_right;
    assign req_stop  = bus.ir_stop;

    state_t state_reg;
    state_t state_next;
    state_t pulse_cmd_reg;
    state_t pulse_cmd_next;
    logic   pulse_reg;
    logic   pulse_next;
    logic   auto_reg;
    logic   auto_next;
    logic   accept;
    state_t accept_cmd;
    logic   wdog_expire;

    // A blocked forward that is the top request leaves the cycle with no accepted command.
    always_comb begin
        accept     = 1'b1;
        accept_cmd = ST_STOP;
        if (req_stop) begin
            accept_cmd = ST_STOP;
        end else if (req_back) begin
            accept_cmd = ST_BACK;
        end else if (req_left) begin
            accept_cmd = ST_LEFT;
        end else if (req_right) begin
            accept_cmd = ST_RIGHT;
        end else if (req_fwd && !bus.hr_flag_short) begin
            accept_cmd = ST_FWD;
        end else begin
            accept = 1'b0;
        end
    end

`ifdef MOTION_CMD_WDOG_EN
    localparam int            WW        = $clog2(WDOG_CYCLES);
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

    logic [WW-1:0] wdog_reg;

    assign wdog_expire = (state_reg != ST_STOP) && (wdog_reg == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_reg <= '0;
        end else if (accept || (state_reg == ST_STOP) || wdog_expire) begin
            wdog_reg <= '0;
        end else begin
            wdog_reg <= wdog_reg + 1'b1;
        end
    end
`else
    // No idle timeout in this build; the expression is constant-false for any legal WDOG_CYCLES.
    assign wdog_expire = (WDOG_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_STOP;
            pulse_reg     <= 1'b0;
            pulse_cmd_reg <= ST_STOP;
            auto_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pulse_reg     <= pulse_next;
            pulse_cmd_reg <= pulse_cmd_next;
            auto_reg      <= auto_next;
        end
    end

    // An accepted command always wins over the internally generated stops.
    always_comb begin
        state_next     = state_reg;
        pulse_next     = 1'b0;
        pulse_cmd_next = ST_STOP;
        auto_next      = 1'b0;
        if (accept) begin
            state_next     = accept_cmd;
            pulse_next     = 1'b1;
            pulse_cmd_next = accept_cmd;
        end else if (((state_reg == ST_FWD) && bus.hr_flag_short) || wdog_expire) begin
            state_next     = ST_STOP;
            pulse_next     = 1'b1;
            pulse_cmd_next = ST_STOP;
            auto_next      = 1'b1;
        end
    end

    always_comb begin
        bus.cmd_forward = pulse_reg && (pulse_cmd_reg == ST_FWD);
        bus.cmd_back    = pulse_reg && (pulse_cmd_reg == ST_BACK);
        bus.cmd_left    = pulse_reg && (pulse_cmd_reg == ST_LEFT);
        bus.cmd_right   = pulse_reg && (pulse_cmd_reg == ST_RIGHT);
        bus.cmd_stop    = pulse_reg && (pulse_cmd_reg == ST_STOP);
        bus.cmd_state   = state_reg;
        bus.auto_stop   = auto_reg;
    end

endmodule

// File: tb/tb_motion_cmd_arbiter.sv
// Bench for motion_cmd_arbiter: vector table, hand-written debounce/watchdog/reset sequences,
// and randomized IR/obstacle traffic against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_motion_cmd_arbiter;

    localparam int DEB  = 4;
    localparam int WDOG = 100;
`ifdef MOTION_CMD_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    // command / IR bit order: 0 fwd, 1 back, 2 left, 3 right, 4 stop
    localparam logic [4:0] F = 5'h01;
    localparam logic [4:0] B = 5'h02;
    localparam logic [4:0] L = 5'h04;
    localparam logic [4:0] R = 5'h08;
    localparam logic [4:0] S = 5'h10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    motion_cmd_arbiter_if bus ();

    motion_cmd_arbiter #(
        .DEB_CYCLES  (DEB),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4:0] ir;
        logic       hr;
        logic [4:0] cmd;
        logic [2:0] st;
        logic       au;
    } vec_t;

    localparam int NVEC = 24;
    vec_t tbl [NVEC];

    int total = 0;
    int bad   = 0;

    int m_state;
    int m_edge;
    int m_last;

    logic [8:0] got;
    logic [8:0] exp_v;
    logic [4:0] ecmd;
    logic       eau;
    logic [4:0] rir;
    logic       rhr;
    int         rate;
    int         lim;

    task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
        total++;
        if (g !== e) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, g, e, $time);
        end
    endtask

    function automatic logic [8:0] pack_out();
        return {bus.auto_stop, bus.cmd_state, bus.cmd_stop, bus.cmd_right,
                bus.cmd_left, bus.cmd_back, bus.cmd_forward};
    endfunction

    function automatic logic [8:0] mk(input logic [4:0] c, input int s, input logic a);
        return {a, 3'(s), c};
    endfunction

    task automatic tick(input logic [4:0] ir, input logic hr);
        {bus.ir_stop, bus.ir_right, bus.ir_left, bus.ir_back, bus.ir_forward} = ir;
        bus.hr_flag_short = hr;
        @(posedge clk);
        #1;
    endtask

    task automatic set_key(input int idx, input logic v);
        case (idx)
            0:       bus.key1 = v;
            1:       bus.key2 = v;
            2:       bus.key3 = v;
            default: bus.key4 = v;
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.key1 = 1'b1; bus.key2 = 1'b1; bus.key3 = 1'b1; bus.key4 = 1'b1;
        {bus.ir_stop, bus.ir_right, bus.ir_left, bus.ir_back, bus.ir_forward} = 5'h00;
        bus.hr_flag_short = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(pack_out()), 32'(0));
        rst_n   = 1'b1;
        m_state = 0;
        m_edge  = 0;
        m_last  = 0;
    endtask

    // Reference: winner from a priority list; state from the winner's index; the idle timeout is
    // the distance in edges since the command that entered the current moving state.
    task automatic model_edge(input logic [4:0] ir, input logic hr,
                              output logic [4:0] c, output logic a);
        int order [5];
        int win;
        order = '{4, 1, 2, 3, 0};
        m_edge++;
        win = -1;
        for (int i = 0; i < 5; i++)
            if (win < 0 && ir[order[i]]) win = order[i];
        if (win == 0 && hr) win = -1;
        c = 5'h00;
        a = 1'b0;
        if (win >= 0) begin
            c       = 5'(1 << win);
            m_state = (win + 1) % 5;
            m_last  = m_edge;
        end else if ((m_state == 1 && hr) ||
                     (WDOG_ON && m_state != 0 && (m_edge - m_last) == WDOG)) begin
            c       = S;
            a       = 1'b1;
            m_state = 0;
        end
    endtask

    task automatic key_test(input int idx, input logic bounce);
        logic [8:0] k;
        if (bounce) begin
            for (int j = 0; j < 8; j++) begin
                set_key(idx, j[1]);
                tick(5'h00, 1'b0);
                k = pack_out();
                check("key_bounce", 32'(k[4:0]), 32'(0));
            end
        end
        set_key(idx, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            tick(5'h00, 1'b0);
            k = pack_out();
            check("key_press_pulse", 32'(k[4:0]), (i == 7) ? 32'(1 << idx) : 32'(0));
        end
        check("key_press_state", 32'(k[7:5]), 32'(idx + 1));
        $display("key%0d press: cmd pulse expected 7 clks after stable edge, state %0d", idx + 1, k[7:5]);
        set_key(idx, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            tick(5'h00, 1'b0);
            k = pack_out();
            check("key_release_quiet", 32'(k[4:0]), 32'(0));
        end
        check("key_release_state", 32'(k[7:5]), 32'(idx + 1));
    endtask

    initial begin
        tbl[0]  = '{5'h00, 1'b0, 5'h00, 3'd0, 1'b0};
        tbl[1]  = '{L,     1'b0, L,     3'd3, 1'b0};
        tbl[2]  = '{5'h00, 1'b0, 5'h00, 3'd3, 1'b0};
        tbl[3]  = '{F,     1'b0, F,     3'd1, 1'b0};
        tbl[4]  = '{5'h00, 1'b1, S,     3'd0, 1'b1};
        tbl[5]  = '{F,     1'b1, 5'h00, 3'd0, 1'b0};
        tbl[6]  = '{B,     1'b1, B,     3'd2, 1'b0};
        tbl[7]  = '{S | F, 1'b0, S,     3'd0, 1'b0};
        tbl[8]  = '{B | R, 1'b0, B,     3'd2, 1'b0};
        tbl[9]  = '{R,     1'b0, R,     3'd4, 1'b0};
        tbl[10] = '{S,     1'b0, S,     3'd0, 1'b0};
        tbl[11] = '{S,     1'b0, S,     3'd0, 1'b0};
        tbl[12] = '{F | R, 1'b1, R,     3'd4, 1'b0};
        tbl[13] = '{F,     1'b1, 5'h00, 3'd4, 1'b0};
        tbl[14] = '{F,     1'b0, F,     3'd1, 1'b0};
        tbl[15] = '{F,     1'b1, S,     3'd0, 1'b1};
        tbl[16] = '{F | L, 1'b0, L,     3'd3, 1'b0};
        tbl[17] = '{L,     1'b1, L,     3'd3, 1'b0};
        tbl[18] = '{F,     1'b0, F,     3'd1, 1'b0};
        tbl[19] = '{B,     1'b1, B,     3'd2, 1'b0};
        tbl[20] = '{S,     1'b0, S,     3'd0, 1'b0};
        tbl[21] = '{B,     1'b0, B,     3'd2, 1'b0};
        tbl[22] = '{L | R, 1'b0, L,     3'd3, 1'b0};
        tbl[23] = '{5'h1f, 1'b1, S,     3'd0, 1'b0};

        // vector table
        do_reset();
        for (int i = 0; i < NVEC; i++) begin
            tick(tbl[i].ir, tbl[i].hr);
            got = pack_out();
            check("table", 32'(got), 32'(mk(tbl[i].cmd, int'(tbl[i].st), tbl[i].au)));
            $display("vec %0d ir=%b hr=%b -> cmd=%b state=%0d auto=%b", i, tbl[i].ir, tbl[i].hr,
                     got[4:0], got[7:5], got[8]);
        end

        // physical keys with bounce on key1, then the other keys cleanly
        do_reset();
        key_test(0, 1'b1);
        key_test(1, 1'b0);
        key_test(2, 1'b0);
        key_test(3, 1'b0);

        // idle timeout after a single right command
        do_reset();
        tick(R, 1'b0);
        check("wdog_right", 32'(pack_out()), 32'(mk(R, 4, 1'b0)));
        lim = WDOG_ON ? 150 : 1000;
        for (int k = 1; k <= lim; k++) begin
            tick(5'h00, 1'b0);
            exp_v = (WDOG_ON && k == WDOG) ? mk(S, 0, 1'b1) :
                    mk(5'h00, (WDOG_ON && k > WDOG) ? 0 : 4, 1'b0);
            check("wdog_single", 32'(pack_out()), 32'(exp_v));
        end
        $display("wdog single: state after %0d idle clks = %0d", lim, bus.cmd_state);

        // repeated right at clk 60 defers the timeout
        do_reset();
        tick(R, 1'b0);
        check("wdog_right2", 32'(pack_out()), 32'(mk(R, 4, 1'b0)));
        for (int k = 1; k <= 200; k++) begin
            tick((k == 60) ? R : 5'h00, 1'b0);
            if (k == 60)
                exp_v = mk(R, 4, 1'b0);
            else if (WDOG_ON && k == 60 + WDOG)
                exp_v = mk(S, 0, 1'b1);
            else
                exp_v = mk(5'h00, (WDOG_ON && k > 60 + WDOG) ? 0 : 4, 1'b0);
            check("wdog_deferred", 32'(pack_out()), 32'(exp_v));
        end
        $display("wdog deferred: final state %0d", bus.cmd_state);

        // reset in FWD with the timeout part-way and a key mid-debounce
        do_reset();
        tick(F, 1'b0);
        check("rst_fwd", 32'(pack_out()), 32'(mk(F, 1, 1'b0)));
        for (int k = 1; k <= 80; k++) begin
            if (k == 78) bus.key2 = 1'b0;
            tick(5'h00, 1'b0);
            check("rst_prefill", 32'(pack_out()), 32'(mk(5'h00, 1, 1'b0)));
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'(pack_out()), 32'(0));
        bus.key2 = 1'b1;
        tick(5'h00, 1'b0);
        check("rst_hold", 32'(pack_out()), 32'(0));
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(5'h00, 1'b0);
            check("rst_release_quiet", 32'(pack_out()), 32'(0));
        end
        $display("reset mid-motion: outputs cleared, no pulse on release");

        // randomized IR / obstacle traffic against the reference model
        do_reset();
        rhr = 1'b0;
        for (int blk = 0; blk < 12; blk++) begin
            rate = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, 10));
            for (int c = 0; c < 250; c++) begin
                for (int b = 0; b < 5; b++) rir[b] = ($urandom_range(0, 99) < rate);
                if ($urandom_range(0, 99) < 4) rhr = ~rhr;
                model_edge(rir, rhr, ecmd, eau);
                tick(rir, rhr);
                check("random", 32'(pack_out()), 32'(mk(ecmd, m_state, eau)));
                if (ecmd != 5'h00)
                    $display("rand edge %0d ir=%b hr=%b -> cmd=%b state=%0d auto=%b",
                             m_edge, rir, rhr, ecmd, m_state, eau);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
